alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational 64-bit ALU.
- Registers operands and opcode on a valid/ready input handshake and returns a registered result with Zero flag on a valid/ready output handshake.
- Adds SLT and an optional iterative shift-add multiplier.
- Sits between the decode/operand-fetch stage and writeback in the multi-cycle datapath.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 133 +++++++++++++
 tb/tb_alu_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode constants and FSM state encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle, LSB first.
// Only instantiated when ALU_SEQ_MUL_EN is defined.
// The product output is the accumulator value after the current iteration,
// so the owner can capture it on the same edge that done is seen.
module alu_mul_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             done
);

  logic             busy;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_next;

  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign product  = acc_next;
  assign done     = busy && (count == CNT_W'(WIDTH - 1));

  // Load operands on start, then add-and-shift once per cycle for WIDTH cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= multiplicand;
      mplier <= multiplier;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: accepts an operation on in_valid/in_ready,
// returns a registered Result/Zero/illegal on out_valid/out_ready.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (opcode 0011);
// without it 0011 completes in one cycle as an illegal opcode.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUOp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             illegal
);

  alu_state_t       state;
  alu_state_t       state_next;
  logic [WIDTH-1:0] alu_res;
  logic             is_legal;
  logic             starts_mul;
  logic             accept;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;

  // in_ready depends on state only, so it never combinationally follows in_valid.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign Result    = result_q;
  assign Zero      = zero_q;
  assign illegal   = illegal_q;

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] mul_product;
  logic             mul_done;

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (accept && starts_mul),
    .multiplicand (a),
    .multiplier   (b),
    .product      (mul_product),
    .done         (mul_done)
  );
`endif

  // Decode the opcode and evaluate every single-cycle operation from the live inputs.
  always_comb begin
    alu_res    = '0;
    is_legal   = 1'b1;
    starts_mul = 1'b0;
    case (ALUOp)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_NOR: alu_res = ~(a | b);
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: starts_mul = 1'b1;
`endif
      default: is_legal = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: multiplies detour through BUSY, everything else goes straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = starts_mul ? BUSY : DONE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      BUSY: begin
        if (mul_done) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result registers: loaded at acceptance for one-cycle ops, or when the multiplier finishes.
  // A multiply clears Zero at acceptance so the flag is never high while BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else if (accept) begin
      result_q  <= alu_res;
      zero_q    <= (alu_res == '0) && !starts_mul;
      illegal_q <= !is_legal;
`ifdef ALU_SEQ_MUL_EN
    end else if ((state == BUSY) && mul_done) begin
      result_q <= mul_product;
      zero_q   <= (mul_product == '0);
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (64-bit instance, plus an 8-bit
// instance exercising the multiplier when ALU_SEQ_MUL_EN is defined).
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  alu_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        zero;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(64)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUOp     (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .Zero      (zero),
    .illegal   (illegal)
  );

`ifdef ALU_SEQ_MUL_EN
  logic       in_valid8;
  logic       in_ready8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic [3:0] alu_op8;
  logic       out_valid8;
  logic [7:0] result8;
  logic       zero8;
  logic       illegal8;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .ALUOp     (alu_op8),
    .out_valid (out_valid8),
    .out_ready (1'b1),
    .Result    (result8),
    .Zero      (zero8),
    .illegal   (illegal8)
  );

  // Multiply on the 8-bit instance: expect WIDTH=8 edges in BUSY, in_ready low and Zero low throughout.
  task automatic run_mul8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_res);
    int edges;
    logic ready_seen;
    logic zero_seen;
    @(negedge clk);
    a8 = av; b8 = bv; alu_op8 = 4'b0011; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    edges = 0;
    ready_seen = 1'b0;
    zero_seen = 1'b0;
    while (!out_valid8 && edges < 40) begin
      ready_seen = ready_seen | in_ready8;
      zero_seen  = zero_seen | zero8;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency_edges"}, 64'(edges), 64'd8);
    check({tag, "_in_ready_low"}, 64'(ready_seen), 64'd0);
    check({tag, "_zero_low_busy"}, 64'(zero_seen), 64'd0);
    check({tag, "_in_ready_done"}, 64'(in_ready8), 64'd0);
    check({tag, "_result"}, 64'(result8), 64'(exp_res));
    check({tag, "_illegal"}, 64'(illegal8), 64'd0);
    @(posedge clk); #1;
    check({tag, "_ret_idle"}, 64'(in_ready8), 64'd1);
  endtask
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation on the 64-bit instance; results must be visible right after the accepting edge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] av,
                        input logic [63:0] bv, input logic [63:0] exp_res,
                        input logic exp_zero, input logic exp_ill);
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = av; b = bv; alu_op = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_zero"}, 64'(zero), 64'(exp_zero));
    check({tag, "_illegal"}, 64'(illegal), 64'(exp_ill));
    if (out_ready) begin
      @(posedge clk); #1;
      check({tag, "_ret_idle"}, 64'(in_ready), 64'd1);
      check({tag, "_ret_nvalid"}, 64'(out_valid), 64'd0);
    end
  endtask

  localparam logic [63:0] VA = 64'h0000000AB000000F;
  localparam logic [63:0] VB = 64'h0002300000000F0F;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; alu_op = '0;
`ifdef ALU_SEQ_MUL_EN
    in_valid8 = 1'b0; a8 = '0; b8 = '0; alu_op8 = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    check("rst_illegal", 64'(illegal), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op("and", 4'b0000, VA, VB, 64'h000000000000000F, 1'b0, 1'b0);
    run_op("or",  4'b0001, VA, VB, 64'h0002300AB0000F0F, 1'b0, 1'b0);
    run_op("add", 4'b0010, VA, VB, 64'h0002300AB0000F1E, 1'b0, 1'b0);
    run_op("sub", 4'b0110, VA, VB, 64'hFFFDD00AAFFFF100, 1'b0, 1'b0);
    run_op("nor", 4'b1100, VA, VB, 64'hFFFDCFF54FFFF0F0, 1'b0, 1'b0);
    run_op("slt", 4'b0111, VA, VB, 64'h1, 1'b0, 1'b0);
    run_op("slt_neg", 4'b0111, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h1, 1'b0, 1'b0);
    run_op("slt_false", 4'b0111, VB, VA, 64'h0, 1'b1, 1'b0);
    run_op("sub_zero", 4'b0110, 64'h5, 64'h5, 64'h0, 1'b1, 1'b0);
    run_op("add_wrap", 4'b0010, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h1, 1'b0, 1'b0);
    run_op("illegal_f", 4'b1111, VA, VB, 64'h0, 1'b1, 1'b1);
`ifndef ALU_SEQ_MUL_EN
    run_op("mul_off", 4'b0011, VA, VB, 64'h0, 1'b1, 1'b1);
`endif

    // Backpressure: result held for 5 cycles with out_ready low.
    out_ready = 1'b0;
    run_op("bp_add", 4'b0010, VA, VB, 64'h0002300AB0000F1E, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; a = 64'h1; b = 64'h1; alu_op = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_result", result, 64'h0002300AB0000F1E);
      check("bp_zero", 64'(zero), 64'd0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    check("bp_release_valid", 64'(out_valid), 64'd0);

    // Reset while holding a result in DONE aborts it asynchronously.
    out_ready = 1'b0;
    run_op("abort_add", 4'b0010, 64'h10, 64'h20, 64'h30, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", result, 64'd0);
    check("abort_zero", 64'(zero), 64'd1);
    check("abort_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    run_op("post_abort_add", 4'b0010, 64'h3, 64'h4, 64'h7, 1'b0, 1'b0);

`ifdef ALU_SEQ_MUL_EN
    run_mul8("mul_d_b", 8'h0D, 8'h0B, 8'h8F);
    run_mul8("mul_f0_3", 8'hF0, 8'h03, 8'hD0);

    // Reset during multiplier cycle 4: no out_valid pulse, outputs at reset values.
    @(negedge clk);
    a8 = 8'h0D; b8 = 8'h0B; alu_op8 = 4'b0011; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mrst_out_valid", 64'(out_valid8), 64'd0);
    check("mrst_result", 64'(result8), 64'd0);
    check("mrst_zero", 64'(zero8), 64'd1);
    check("mrst_illegal", 64'(illegal8), 64'd0);
    check("mrst_in_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    begin
      logic valid_seen;
      valid_seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        valid_seen = valid_seen | out_valid8;
      end
      check("mrst_no_pulse", 64'(valid_seen), 64'd0);
    end
    @(negedge clk);
    a8 = 8'h03; b8 = 8'h04; alu_op8 = 4'b0010; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    check("mrst_add_valid", 64'(out_valid8), 64'd1);
    check("mrst_add_result", 64'(result8), 64'd7);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
